// File: rtl/cpu_boot_pkg.sv
// Shared boot-loader types: FSM state encoding and default memory geometry.
package cpu_boot_pkg;

   localparam int unsigned IMEM_DEPTH_DEF = 256;
   localparam int unsigned HDR_BYTES      = 2;

   typedef enum logic [2:0] {
      StClear,
      StLenLo,
      StLenHi,
      StData,
      StRun,
      StErr
   } boot_state_e;

endpackage

// File: rtl/imem_boot_loader.sv
// Byte-stream instruction-memory loader: 16-bit word-count header, little-endian words, then
// releases the CPU. Define BOOT_CLEAR_EN to zero the whole memory before accepting the header.
module imem_boot_loader
   import cpu_boot_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter int unsigned AW         = 8
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          byte_valid_i,
   input  logic [7:0]    byte_i,
   output logic          byte_ready_o,
   output logic          imem_we_o,
   output logic [AW-1:0] imem_addr_o,
   output logic [31:0]   imem_data_o,
   output logic          cpu_start_o,
   output logic          err_o
);

   localparam int unsigned CntW = AW + 1;

`ifdef BOOT_CLEAR_EN
   localparam boot_state_e ResetSt = StClear;
`else
   localparam boot_state_e ResetSt = StLenLo;
`endif

   boot_state_e     state_q, state_d;
   logic [7:0]      len_lo_q, len_lo_d;
   logic [15:0]     len_q, len_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      bcnt_q, bcnt_d;
   logic [23:0]     shift_q, shift_d;
   logic            ready_q, ready_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [31:0]     data_q, data_d;
   logic            start_q, start_d;
   logic            err_q, err_d;

   logic            xfer;
   logic [15:0]     hdr_n;

   assign xfer  = byte_valid_i & ready_q;
   assign hdr_n = {byte_i, len_lo_q};

   always_comb begin
      state_d  = state_q;
      len_lo_d = len_lo_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      bcnt_d   = bcnt_q;
      shift_d  = shift_q;
      addr_d   = addr_q;
      data_d   = data_q;
      we_d     = 1'b0;

      unique case (state_q)
`ifdef BOOT_CLEAR_EN
         StClear: begin
            we_d   = 1'b1;
            addr_d = cnt_q[AW-1:0];
            data_d = '0;
            if (cnt_q == CntW'(IMEM_DEPTH - 1)) begin
               cnt_d   = '0;
               state_d = StLenLo;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         StLenLo: begin
            if (xfer) begin
               len_lo_d = byte_i;
               state_d  = StLenHi;
            end
         end
         StLenHi: begin
            if (xfer) begin
               len_d = hdr_n;
               if ({1'b0, hdr_n} > 17'(IMEM_DEPTH)) begin
                  state_d = StErr;
               end else if (hdr_n == 16'd0) begin
                  state_d = StRun;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (we_q) begin
               // Write of the last word is on the bus this cycle; release the CPU next.
               if (16'(cnt_q) == len_q) begin
                  state_d = StRun;
               end
            end else if (xfer) begin
               bcnt_d  = bcnt_q + 1'b1;
               shift_d = {byte_i, shift_q[23:8]};
               if (bcnt_q == 2'd3) begin
                  we_d   = 1'b1;
                  addr_d = cnt_q[AW-1:0];
                  data_d = {byte_i, shift_q};
                  cnt_d  = cnt_q + 1'b1;
               end
            end
         end
         StRun, StErr: begin
            state_d = state_q;
         end
         default: begin
            state_d = StLenLo;
         end
      endcase

      ready_d = (state_d inside {StLenLo, StLenHi, StData}) && !we_d;
      start_d = (state_d == StRun);
      err_d   = (state_d == StErr);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ResetSt;
         len_lo_q <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         bcnt_q   <= '0;
         shift_q  <= '0;
         ready_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         start_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_lo_q <= len_lo_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         bcnt_q   <= bcnt_d;
         shift_q  <= shift_d;
         ready_q  <= ready_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         start_q  <= start_d;
         err_q    <= err_d;
      end
   end

   assign byte_ready_o = ready_q;
   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_data_o  = data_q;
   assign cpu_start_o  = start_q;
   assign err_o        = err_q;

endmodule
